pkt_filter_table: RTL

PKT_FILTER_TABLE -- requirements
Module: pkt_filter_table

---
 rtl/pkt_filter_table_if.sv | 32 +++
 rtl/pkt_filter_table.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_filter_table_if.sv
// Header, configuration and decision signals of the packet filter table.
// The master drives headers/config and takes decisions; the slave is the filter.
interface pkt_filter_table_if #(
  parameter int unsigned NUM_RULES = 4
);
  localparam int unsigned RW = $clog2(NUM_RULES);
  localparam int unsigned AW = RW + 3;

  logic [511:0]  hdr_data;
  logic          hdr_valid;
  logic          hdr_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_waddr;
  logic [31:0]   cfg_wdata;
  logic [AW-1:0] cfg_raddr;
  logic [31:0]   cfg_rdata;
  logic          dec_valid;
  logic          dec_ready;
  logic          dec_match;
  logic [RW-1:0] dec_rule;
  logic          dec_accept;

  modport master (
    output hdr_data, hdr_valid, cfg_we, cfg_waddr, cfg_wdata, cfg_raddr, dec_ready,
    input  hdr_ready, cfg_rdata, dec_valid, dec_match, dec_rule, dec_accept
  );

  modport slave (
    input  hdr_data, hdr_valid, cfg_we, cfg_waddr, cfg_wdata, cfg_raddr, dec_ready,
    output hdr_ready, cfg_rdata, dec_valid, dec_match, dec_rule, dec_accept
  );
endinterface

// File: rtl/pkt_filter_table.sv
// Two-stage UDP/IPv4 header classifier against NUM_RULES configurable rules,
// with lowest-index priority and saturating per-rule hit counters.
module pkt_filter_table #(
  parameter int unsigned NUM_RULES = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pkt_filter_table_if.slave bus
);
  localparam int unsigned RW = $clog2(NUM_RULES);
  localparam int unsigned AW = RW + 3;

  typedef struct packed {
    logic        en;
    logic        act;
    logic [47:0] mac;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [31:0] ip_base;
    logic [31:0] ip_mask;
    logic [15:0] port_mask;
    logic [15:0] port;
  } rule_t;

  rule_t            r_rule [NUM_RULES];
  logic [CNT_W-1:0] r_cnt  [NUM_RULES];

  logic                 r_s1_valid;
  logic [NUM_RULES-1:0] r_s1_match;
  logic [NUM_RULES-1:0] r_s1_act;
  logic                 r_dec_valid;
  logic                 r_dec_match;
  logic [RW-1:0]        r_dec_rule;
  logic                 r_dec_accept;

  logic                 w_adv;
  logic [NUM_RULES-1:0] w_match;
  logic [NUM_RULES-1:0] w_act;
  logic [RW-1:0]        w_win;
  logic                 w_any;
  logic                 w_inc;
  logic [RW-1:0]        w_wrule;
  logic [2:0]           w_wword;
  logic [RW-1:0]        w_rrule;
  logic [2:0]           w_rword;
  logic [31:0]          w_rdata;
  rule_t                w_rsel;

  // Header field extraction; byte k lives at bits [511-8k -: 8]
  logic [47:0] w_mac;
  logic [15:0] w_etype;
  logic [3:0]  w_ver;
  logic [3:0]  w_ihl;
  logic [7:0]  w_proto;
  logic [31:0] w_ip;
  logic [15:0] w_port;
  logic        w_unused;

  assign w_mac    = bus.hdr_data[511:464];
  assign w_etype  = bus.hdr_data[415:400];
  assign w_ver    = bus.hdr_data[399:396];
  assign w_ihl    = bus.hdr_data[395:392];
  assign w_proto  = bus.hdr_data[327:320];
  assign w_ip     = bus.hdr_data[271:240];
  assign w_port   = bus.hdr_data[223:208];
  assign w_unused = &{1'b0, bus.hdr_data[463:416], bus.hdr_data[391:328],
                      bus.hdr_data[319:272], bus.hdr_data[239:224], bus.hdr_data[207:0]};

  assign w_adv         = !r_dec_valid || bus.dec_ready;
  assign bus.hdr_ready = w_adv;

  assign w_wrule = bus.cfg_waddr[AW-1:3];
  assign w_wword = bus.cfg_waddr[2:0];
  assign w_rrule = bus.cfg_raddr[AW-1:3];
  assign w_rword = bus.cfg_raddr[2:0];

  // Per-rule compare against the configuration currently held in the registers
  always_comb begin
    w_match = '0;
    w_act   = '0;
    for (int r = 0; r < int'(NUM_RULES); r++) begin
      w_act[r]   = r_rule[r].act;
      w_match[r] = r_rule[r].en
                && (w_mac   == r_rule[r].mac)
                && (w_etype == r_rule[r].etype)
                && (w_ver   == 4'd4)
                && (w_ihl   == 4'd5)
                && (w_proto == r_rule[r].proto)
                && ((w_ip & r_rule[r].ip_mask) == (r_rule[r].ip_base & r_rule[r].ip_mask))
                && ((w_port & r_rule[r].port_mask) == (r_rule[r].port & r_rule[r].port_mask));
    end
  end

  // Stage 1: match vector and rule actions captured at the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
      r_s1_act   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= bus.hdr_valid;
      r_s1_match <= bus.hdr_valid ? w_match : '0;
      r_s1_act   <= w_act;
    end
  end

  // Lowest matching index wins
  always_comb begin
    w_win = '0;
    w_any = |r_s1_match;
    for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
      if (r_s1_match[i]) w_win = RW'(i);
    end
  end

  // Stage 2: registered decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_valid  <= 1'b0;
      r_dec_match  <= 1'b0;
      r_dec_rule   <= '0;
      r_dec_accept <= 1'b0;
    end else if (w_adv) begin
      r_dec_valid  <= r_s1_valid;
      r_dec_match  <= w_any;
      r_dec_rule   <= w_win;
      r_dec_accept <= w_any && r_s1_act[w_win];
    end
  end

  assign bus.dec_valid  = r_dec_valid;
  assign bus.dec_match  = r_dec_match;
  assign bus.dec_rule   = r_dec_rule;
  assign bus.dec_accept = r_dec_accept;

  // Rule configuration registers (words 0-6)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_RULES); r++) r_rule[r] <= '0;
    end else if (bus.cfg_we) begin
      for (int r = 0; r < int'(NUM_RULES); r++) begin
        if (w_wrule == RW'(r)) begin
          case (w_wword)
            3'd0: begin
              r_rule[r].en  <= bus.cfg_wdata[0];
              r_rule[r].act <= bus.cfg_wdata[1];
            end
            3'd1: r_rule[r].mac[47:32] <= bus.cfg_wdata[15:0];
            3'd2: r_rule[r].mac[31:0]  <= bus.cfg_wdata;
            3'd3: begin
              r_rule[r].etype <= bus.cfg_wdata[31:16];
              r_rule[r].proto <= bus.cfg_wdata[7:0];
            end
            3'd4: r_rule[r].ip_base <= bus.cfg_wdata;
            3'd5: r_rule[r].ip_mask <= bus.cfg_wdata;
            3'd6: begin
              r_rule[r].port_mask <= bus.cfg_wdata[31:16];
              r_rule[r].port      <= bus.cfg_wdata[15:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign w_inc = r_dec_valid && bus.dec_ready && r_dec_match;

  // Hit counters: saturating increment, a word-7 write clears and overrides it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_RULES); r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_RULES); r++) begin
        if (bus.cfg_we && (w_wrule == RW'(r)) && (w_wword == 3'd7)) begin
          r_cnt[r] <= '0;
        end else if (w_inc && (r_dec_rule == RW'(r)) && (r_cnt[r] != {CNT_W{1'b1}})) begin
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        end
      end
    end
  end

  // Combinational config read-back; unused bits read as zero
  always_comb begin
    w_rsel  = r_rule[w_rrule];
    w_rdata = '0;
    case (w_rword)
      3'd0:    w_rdata = {30'd0, w_rsel.act, w_rsel.en};
      3'd1:    w_rdata = {16'd0, w_rsel.mac[47:32]};
      3'd2:    w_rdata = w_rsel.mac[31:0];
      3'd3:    w_rdata = {w_rsel.etype, 8'd0, w_rsel.proto};
      3'd4:    w_rdata = w_rsel.ip_base;
      3'd5:    w_rdata = w_rsel.ip_mask;
      3'd6:    w_rdata = {w_rsel.port_mask, w_rsel.port};
      default: w_rdata = 32'(r_cnt[w_rrule]);
    endcase
  end

  assign bus.cfg_rdata = w_rdata;

endmodule
